// File: rtl/glb_port_arbiter.sv
// glb_port_arbiter: shares the single GLB read/write port between the host
// DRAM load/unload path (index 0) and the pass controller (index 1).
// Round-robin grant with burst locking, a forced re-arbitration after
// BURST_MAX beats, and 1-cycle read data routed back to the issuing side.
module glb_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_MAX = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ctrl_only,
   // host requester
   input  logic                h_req_valid,
   output logic                h_req_ready,
   input  logic                h_req_wr,
   input  logic [DATA_W/8-1:0] h_req_be,
   input  logic [ADDR_W-1:0]   h_req_addr,
   input  logic [DATA_W-1:0]   h_req_wdata,
   input  logic                h_req_last,
   output logic                h_rsp_valid,
   output logic [DATA_W-1:0]   h_rsp_data,
   // controller requester
   input  logic                c_req_valid,
   output logic                c_req_ready,
   input  logic                c_req_wr,
   input  logic [DATA_W/8-1:0] c_req_be,
   input  logic [ADDR_W-1:0]   c_req_addr,
   input  logic [DATA_W-1:0]   c_req_wdata,
   input  logic                c_req_last,
   output logic                c_rsp_valid,
   output logic [DATA_W-1:0]   c_rsp_data,
   // GLB port
   output logic [DATA_W/8-1:0] glb_re,
   output logic [ADDR_W-1:0]   glb_r_addr,
   input  logic [DATA_W-1:0]   glb_dout,
   output logic [DATA_W/8-1:0] glb_we,
   output logic [ADDR_W-1:0]   glb_w_addr,
   output logic [DATA_W-1:0]   glb_din,
   output logic                busy
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(BURST_MAX + 1);

   typedef enum logic [1:0] {IDLE, GNT_H, GNT_C} state_t;

   state_t            state, state_nxt;
   logic              last_owner;   // 0 = host held the last grant, 1 = controller
   logic [CNT_W-1:0]  beat_cnt;
   logic              rd_pend;
   logic              rd_tag;       // 0 = host, 1 = controller

   // fields of whichever requester currently owns the port (all 0 in IDLE)
   logic              g_valid, g_wr, g_last;
   logic [BE_W-1:0]   g_be;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata;
   logic              accept, burst_end, h_elig, c_elig;

   // select the granted requester's beat; IDLE presents nothing to the GLB
   always_comb begin
      g_valid = 1'b0;
      g_wr    = 1'b0;
      g_last  = 1'b0;
      g_be    = '0;
      g_addr  = '0;
      g_wdata = '0;
      unique case (state)
         GNT_H: begin
            g_valid = h_req_valid;
            g_wr    = h_req_wr;
            g_last  = h_req_last;
            g_be    = h_req_be;
            g_addr  = h_req_addr;
            g_wdata = h_req_wdata;
         end
         GNT_C: begin
            g_valid = c_req_valid;
            g_wr    = c_req_wr;
            g_last  = c_req_last;
            g_be    = c_req_be;
            g_addr  = c_req_addr;
            g_wdata = c_req_wdata;
         end
         default: ;
      endcase
   end

   assign h_elig    = h_req_valid & ~ctrl_only;
   assign c_elig    = c_req_valid;
   assign accept    = g_valid;  // ready is implied by a grant state
   // the beat being accepted now is either the burst's last or the BURST_MAX-th
   assign burst_end = accept & (g_last | (beat_cnt == CNT_W'(BURST_MAX - 1)));

   // next-state: arbitrate in IDLE, hold the grant until the burst ends
   always_comb begin
      state_nxt   = state;
      h_req_ready = 1'b0;
      c_req_ready = 1'b0;
      unique case (state)
         IDLE: begin
            // both eligible: the one that did not hold the last grant wins
            if (h_elig && (!c_elig || last_owner)) state_nxt = GNT_H;
            else if (c_elig)                       state_nxt = GNT_C;
         end
         GNT_H: begin
            h_req_ready = 1'b1;
            if (burst_end) state_nxt = IDLE;
         end
         GNT_C: begin
            c_req_ready = 1'b1;
            if (burst_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // GLB drive follows the accepted beat combinationally
   assign glb_r_addr = g_addr;
   assign glb_w_addr = g_addr;
   assign glb_din    = g_wdata;
   assign glb_we     = (accept &  g_wr) ? g_be : '0;
   assign glb_re     = (accept & ~g_wr) ? g_be : '0;

   // grant state, round-robin history and per-grant beat count
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         beat_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            beat_cnt <= '0;
            if (state_nxt == GNT_H) last_owner <= 1'b0;
            if (state_nxt == GNT_C) last_owner <= 1'b1;
         end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   // remember who issued each read so next cycle's data goes back to them
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend <= 1'b0;
         rd_tag  <= 1'b0;
      end else begin
         rd_pend <= accept & ~g_wr;
         rd_tag  <= (state == GNT_C);
      end
   end

   assign h_rsp_valid = rd_pend & ~rd_tag;
   assign c_rsp_valid = rd_pend &  rd_tag;
   assign h_rsp_data  = h_rsp_valid ? glb_dout : '0;
   assign c_rsp_data  = c_rsp_valid ? glb_dout : '0;
   assign busy        = (state != IDLE) | rd_pend;

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Bench for glb_port_arbiter: directed scenarios with literal expectations,
// plus a cycle-level model of the grant/response rules checked every cycle.
module tb_glb_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int BM = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ctrl_only = 1'b0;
   logic          h_req_valid = 1'b0, h_req_wr = 1'b0, h_req_last = 1'b0;
   logic [BW-1:0] h_req_be = '0;
   logic [AW-1:0] h_req_addr = '0;
   logic [DW-1:0] h_req_wdata = '0;
   logic          c_req_valid = 1'b0, c_req_wr = 1'b0, c_req_last = 1'b0;
   logic [BW-1:0] c_req_be = '0;
   logic [AW-1:0] c_req_addr = '0;
   logic [DW-1:0] c_req_wdata = '0;
   logic [DW-1:0] glb_dout = '0;
   logic          h_req_ready, c_req_ready, h_rsp_valid, c_rsp_valid, busy;
   logic [DW-1:0] h_rsp_data, c_rsp_data, glb_din;
   logic [BW-1:0] glb_re, glb_we;
   logic [AW-1:0] glb_r_addr, glb_w_addr;

   always #5 clk = ~clk;

   glb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
      .clk(clk), .rst(rst), .ctrl_only(ctrl_only),
      .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_wr(h_req_wr),
      .h_req_be(h_req_be), .h_req_addr(h_req_addr), .h_req_wdata(h_req_wdata),
      .h_req_last(h_req_last), .h_rsp_valid(h_rsp_valid), .h_rsp_data(h_rsp_data),
      .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_wr(c_req_wr),
      .c_req_be(c_req_be), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
      .c_req_last(c_req_last), .c_rsp_valid(c_rsp_valid), .c_rsp_data(c_rsp_data),
      .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_dout(glb_dout),
      .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_din(glb_din), .busy(busy)
   );

   // GLB memory stand-in: reads return address + 1 one cycle later, junk otherwise
   always @(posedge clk)
      glb_dout <= (glb_re != '0) ? glb_r_addr + 32'd1 : 32'hDEAD_BEEF;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner: 0 none, 1 host, 2 controller. prefer_host: host wins the next tie.
   int            m_owner = 0;
   int            m_beats = 0;
   bit            m_prefer_host = 1'b1;
   bit            m_on = 1'b0;
   int            m_rsp_to = 0;        // 0 no response due, 1 host, 2 controller
   logic [AW-1:0] m_rsp_addr = '0;
   logic          e_v, e_wr, e_last;
   logic [BW-1:0] e_be;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;

   always @(negedge clk) begin
      e_v = 1'b0; e_wr = 1'b0; e_last = 1'b0; e_be = '0; e_addr = '0; e_data = '0;
      if (m_owner == 1) begin
         e_v = h_req_valid; e_wr = h_req_wr; e_last = h_req_last;
         e_be = h_req_be; e_addr = h_req_addr; e_data = h_req_wdata;
      end else if (m_owner == 2) begin
         e_v = c_req_valid; e_wr = c_req_wr; e_last = c_req_last;
         e_be = c_req_be; e_addr = c_req_addr; e_data = c_req_wdata;
      end
      if (m_on) begin
         check("m_h_ready", h_req_ready, m_owner == 1);
         check("m_c_ready", c_req_ready, m_owner == 2);
         check("m_glb_we", glb_we, (e_v && e_wr) ? e_be : '0);
         check("m_glb_re", glb_re, (e_v && !e_wr) ? e_be : '0);
         check("m_glb_r_addr", glb_r_addr, e_addr);
         check("m_glb_w_addr", glb_w_addr, e_addr);
         check("m_glb_din", glb_din, e_data);
         check("m_h_rsp_valid", h_rsp_valid, m_rsp_to == 1);
         check("m_c_rsp_valid", c_rsp_valid, m_rsp_to == 2);
         check("m_h_rsp_data", h_rsp_data, (m_rsp_to == 1) ? m_rsp_addr + 32'd1 : 32'd0);
         check("m_c_rsp_data", c_rsp_data, (m_rsp_to == 2) ? m_rsp_addr + 32'd1 : 32'd0);
         check("m_busy", busy, (m_owner != 0) || (m_rsp_to != 0));
      end
      // advance to what must hold after the coming rising edge
      if (rst) begin
         m_on = 1'b1; m_owner = 0; m_beats = 0; m_prefer_host = 1'b1; m_rsp_to = 0;
      end else begin
         m_rsp_to   = (e_v && !e_wr) ? m_owner : 0;
         m_rsp_addr = e_addr;
         if (m_owner == 0) begin
            if (h_req_valid && !ctrl_only && (!c_req_valid || m_prefer_host)) begin
               m_owner = 1; m_beats = 0; m_prefer_host = 1'b0;
            end else if (c_req_valid) begin
               m_owner = 2; m_beats = 0; m_prefer_host = 1'b1;
            end
         end else if (e_v) begin
            m_beats++;
            if (e_last || m_beats == BM) m_owner = 0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   int  hb, first_c, h_pre, h_tot, last_h;
   bit  hacc, cacc;

   initial begin
      // reset state
      at_neg;
      check("rst_h_ready", h_req_ready, 1'b0);
      check("rst_c_ready", c_req_ready, 1'b0);
      check("rst_glb_we", glb_we, 4'h0);
      check("rst_glb_re", glb_re, 4'h0);
      check("rst_glb_w_addr", glb_w_addr, 32'h0);
      check("rst_busy", busy, 1'b0);
      step;
      rst = 1'b0;

      // host-only 4-beat write burst
      h_req_valid = 1'b1; h_req_wr = 1'b1; h_req_be = 4'hF;
      h_req_addr = 32'h0; h_req_wdata = 32'h11; h_req_last = 1'b0;
      at_neg;
      check("t1_arb_ready", h_req_ready, 1'b0);
      check("t1_arb_we", glb_we, 4'h0);
      step;
      for (int i = 0; i < 4; i++) begin
         h_req_addr  = 32'(4 * i);
         h_req_wdata = 32'(17 * (i + 1));
         h_req_last  = (i == 3);
         at_neg;
         check("t1_ready", h_req_ready, 1'b1);
         check("t1_we", glb_we, 4'hF);
         check("t1_w_addr", glb_w_addr, 32'(4 * i));
         check("t1_din", glb_din, 32'(17 * (i + 1)));
         step;
      end
      h_req_valid = 1'b0; h_req_last = 1'b0;
      at_neg;
      check("t1_idle_ready", h_req_ready, 1'b0);
      check("t1_busy_low", busy, 1'b0);
      step;

      // controller 3-beat read burst from 0x100
      c_req_valid = 1'b1; c_req_wr = 1'b0; c_req_be = 4'hF;
      c_req_addr = 32'h100; c_req_last = 1'b0;
      at_neg;
      check("t2_arb_ready", c_req_ready, 1'b0);
      step;
      at_neg;
      check("t2_re0", glb_re, 4'hF);
      check("t2_raddr0", glb_r_addr, 32'h100);
      check("t2_rsp_none", c_rsp_valid, 1'b0);
      step;
      c_req_addr = 32'h104;
      at_neg;
      check("t2_re1", glb_re, 4'hF);
      check("t2_rsp0_v", c_rsp_valid, 1'b1);
      check("t2_rsp0_d", c_rsp_data, 32'h101);
      check("t2_h_rsp0", h_rsp_valid, 1'b0);
      step;
      c_req_addr = 32'h108; c_req_last = 1'b1;
      at_neg;
      check("t2_rsp1_v", c_rsp_valid, 1'b1);
      check("t2_rsp1_d", c_rsp_data, 32'h105);
      check("t2_h_rsp1", h_rsp_valid, 1'b0);
      step;
      c_req_valid = 1'b0; c_req_last = 1'b0;
      at_neg;
      check("t2_rsp2_v", c_rsp_valid, 1'b1);
      check("t2_rsp2_d", c_rsp_data, 32'h109);
      check("t2_h_rsp2", h_rsp_valid, 1'b0);
      check("t2_busy_pend", busy, 1'b1);
      check("t2_idle_ready", c_req_ready, 1'b0);
      step;
      at_neg;
      check("t2_rsp_done", c_rsp_valid, 1'b0);
      check("t2_busy_low", busy, 1'b0);

      // both requesting after reset: strict alternation, host first
      rst = 1'b1;
      step;
      rst = 1'b0;
      h_req_valid = 1'b1; h_req_wr = 1'b1; h_req_last = 1'b1; h_req_addr = 32'h200; h_req_wdata = 32'hAA;
      c_req_valid = 1'b1; c_req_wr = 1'b1; c_req_last = 1'b1; c_req_addr = 32'h300; c_req_wdata = 32'hCC;
      for (int k = 0; k < 6; k++) begin
         at_neg;
         check("t3_arb_h", h_req_ready, 1'b0);
         check("t3_arb_c", c_req_ready, 1'b0);
         step;
         at_neg;
         check("t3_h_gnt", h_req_ready, (k % 2) == 0);
         check("t3_c_gnt", c_req_ready, (k % 2) == 1);
         check("t3_w_addr", glb_w_addr, ((k % 2) == 0) ? 32'h200 : 32'h300);
         step;
      end

      // 20-beat host burst against a waiting controller: forced split at 16
      h_req_last = 1'b0;
      c_req_addr = 32'h3C0;
      hb = 0; first_c = -1; h_pre = 0; h_tot = 0; last_h = -1;
      for (int t = 0; t < 40; t++) begin
         h_req_addr  = 32'(hb * 4);
         h_req_wdata = 32'(hb);
         h_req_last  = (hb == 19);
         at_neg;
         hacc = h_req_ready && h_req_valid;
         cacc = c_req_ready && c_req_valid;
         if (hacc) begin
            h_tot++;
            last_h = t;
            if (first_c < 0) h_pre++;
         end
         if (cacc && first_c < 0) first_c = t;
         step;
         if (hacc) hb++;
         if (cacc) c_req_valid = 1'b0;
         if (hb == 20) h_req_valid = 1'b0;
         if (hb == 20 && !c_req_valid) break;
      end
      h_req_last = 1'b0;
      check("t4_host_before_split", 64'(h_pre), 64'd16);
      check("t4_ctrl_cycle", 64'(first_c), 64'd18);
      check("t4_host_total", 64'(h_tot), 64'd20);
      check("t4_host_last_cycle", 64'(last_h), 64'd23);

      // ctrl_only blocks the host until it falls
      ctrl_only = 1'b1;
      h_req_valid = 1'b1; h_req_wr = 1'b1; h_req_last = 1'b1; h_req_addr = 32'h500; h_req_wdata = 32'h55;
      for (int i = 0; i < 10; i++) begin
         at_neg;
         check("t5_blocked_ready", h_req_ready, 1'b0);
         check("t5_blocked_we", glb_we, 4'h0);
         check("t5_blocked_re", glb_re, 4'h0);
         step;
      end
      ctrl_only = 1'b0;
      at_neg;
      check("t5_arb_ready", h_req_ready, 1'b0);
      step;
      at_neg;
      check("t5_host_gnt", h_req_ready, 1'b1);
      check("t5_host_we", glb_we, 4'hF);
      step;
      h_req_valid = 1'b0; h_req_last = 1'b0;

      // reset the cycle after an accepted controller read, mid-burst
      c_req_valid = 1'b1; c_req_wr = 1'b0; c_req_last = 1'b0; c_req_addr = 32'h40;
      at_neg;
      step;
      at_neg;
      check("t6_read_re", glb_re, 4'hF);
      step;
      c_req_valid = 1'b0;
      rst = 1'b1;
      at_neg;
      step;
      rst = 1'b0;
      at_neg;
      check("t6_rsp_dropped", c_rsp_valid, 1'b0);
      check("t6_c_ready", c_req_ready, 1'b0);
      check("t6_re", glb_re, 4'h0);
      check("t6_we", glb_we, 4'h0);
      check("t6_busy", busy, 1'b0);
      h_req_valid = 1'b1; h_req_wr = 1'b1; h_req_last = 1'b1; h_req_addr = 32'h80; h_req_wdata = 32'hAB;
      step;
      at_neg;
      check("t6_host_ready", h_req_ready, 1'b1);
      check("t6_host_we", glb_we, 4'hF);
      check("t6_host_addr", glb_w_addr, 32'h80);
      check("t6_host_din", glb_din, 32'hAB);
      step;
      h_req_valid = 1'b0; h_req_last = 1'b0;
      at_neg;
      check("t6_busy_end", busy, 1'b0);
      step;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
